// File: rtl/pir_motion_ctrl.sv
// PIR motion sequencer: warm-up, glitch confirm, retriggerable hold and re-arm lockout, all paced by tick.
// Build option: define PIR_ACTIVE_LOW_EN for sensors whose output is active-low (open-drain).
module pir_motion_ctrl #(
   parameter int WARMUP_TICKS  = 30,
   parameter int CONFIRM_TICKS = 3,
   parameter int HOLD_TICKS    = 10,
   parameter int LOCKOUT_TICKS = 2,
   parameter int CNT_W         = 16
) (
   input  logic             hwclk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             pir_in,
   input  logic             enable,
   output logic             ready,
   output logic             motion_detected,
   output logic             motion_pulse,
   output logic             led_out,
   output logic [CNT_W-1:0] event_count,
   output logic [2:0]       state_dbg
);

   typedef enum logic [2:0] {
      ST_WARMUP  = 3'd0,
      ST_IDLE    = 3'd1,
      ST_CONFIRM = 3'd2,
      ST_ACTIVE  = 3'd3,
      ST_LOCKOUT = 3'd4
   } state_t;

   // Limits are compared one bit wider than the counter so a limit of 2**CNT_W is still reachable.
   localparam logic [CNT_W:0] WARM_LIM    = (CNT_W+1)'(WARMUP_TICKS);
   localparam logic [CNT_W:0] CONFIRM_LIM = (CNT_W+1)'(CONFIRM_TICKS);
   localparam logic [CNT_W:0] HOLD_LIM    = (CNT_W+1)'(HOLD_TICKS);
   localparam logic [CNT_W:0] LOCK_LIM    = (CNT_W+1)'(LOCKOUT_TICKS);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [CNT_W:0]   cnt_inc_s;
   logic             pir_raw_s;
   logic             sync1_r;
   logic             pir_s;
   logic             active_entry_s;
   logic             ready_r;
   logic             motion_detected_r;
   logic             motion_pulse_r;
   logic             led_r;
   logic [CNT_W-1:0] event_count_r;

`ifdef PIR_ACTIVE_LOW_EN
   assign pir_raw_s = ~pir_in;
`else
   assign pir_raw_s = pir_in;
`endif

   assign cnt_inc_s      = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};
   assign active_entry_s = (state_nxt_s == ST_ACTIVE) && (state_r != ST_ACTIVE);

   // Next-state and tick counter; disable and a falling pir_s take priority over a coincident tick.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         ST_WARMUP: begin
            if (tick) begin
               if (cnt_inc_s == WARM_LIM) begin
                  state_nxt_s = ST_IDLE;
                  cnt_nxt_s   = {CNT_W{1'b0}};
               end else begin
                  cnt_nxt_s = cnt_inc_s[CNT_W-1:0];
               end
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end
         ST_IDLE: begin
            if (enable && pir_s) begin
               state_nxt_s = ST_CONFIRM;
               cnt_nxt_s   = {CNT_W{1'b0}};
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_CONFIRM: begin
            if (!enable || !pir_s) begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = {CNT_W{1'b0}};
            end else if (tick) begin
               if (cnt_inc_s == CONFIRM_LIM) begin
                  state_nxt_s = ST_ACTIVE;
                  cnt_nxt_s   = {CNT_W{1'b0}};
               end else begin
                  cnt_nxt_s = cnt_inc_s[CNT_W-1:0];
               end
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end
         ST_ACTIVE: begin
            // Sensor still high keeps the hold timer parked at zero (retrigger).
            if (!enable) begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = {CNT_W{1'b0}};
            end else if (pir_s) begin
               cnt_nxt_s = {CNT_W{1'b0}};
            end else if (tick) begin
               if (cnt_inc_s == HOLD_LIM) begin
                  state_nxt_s = ST_LOCKOUT;
                  cnt_nxt_s   = {CNT_W{1'b0}};
               end else begin
                  cnt_nxt_s = cnt_inc_s[CNT_W-1:0];
               end
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end
         ST_LOCKOUT: begin
            if (!enable) begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = {CNT_W{1'b0}};
            end else if (tick) begin
               if (cnt_inc_s == LOCK_LIM) begin
                  state_nxt_s = ST_IDLE;
                  cnt_nxt_s   = {CNT_W{1'b0}};
               end else begin
                  cnt_nxt_s = cnt_inc_s[CNT_W-1:0];
               end
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end
         default: begin
            state_nxt_s = ST_WARMUP;
            cnt_nxt_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   // Synchroniser, FSM state and registered outputs decoded from the next state.
   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r           <= 1'b0;
         pir_s             <= 1'b0;
         state_r           <= ST_WARMUP;
         cnt_r             <= {CNT_W{1'b0}};
         ready_r           <= 1'b0;
         motion_detected_r <= 1'b0;
         motion_pulse_r    <= 1'b0;
         led_r             <= 1'b0;
         event_count_r     <= {CNT_W{1'b0}};
      end else begin
         sync1_r           <= pir_raw_s;
         pir_s             <= sync1_r;
         state_r           <= state_nxt_s;
         cnt_r             <= cnt_nxt_s;
         ready_r           <= ready_r | (state_nxt_s != ST_WARMUP);
         motion_detected_r <= (state_nxt_s == ST_ACTIVE);
         led_r             <= (state_nxt_s == ST_ACTIVE);
         motion_pulse_r    <= active_entry_s;
         if (active_entry_s && !(&event_count_r)) begin
            event_count_r <= event_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            event_count_r <= event_count_r;
         end
      end
   end

   assign ready           = ready_r;
   assign motion_detected = motion_detected_r;
   assign motion_pulse    = motion_pulse_r;
   assign led_out         = led_r;
   assign event_count     = event_count_r;
   assign state_dbg       = state_r;

endmodule
